stream_demux: RTL

//   Parametrised 1:NUM_CH stream demultiplexer with valid/ready handshake, packet lock and a registered output slot per channel.

---
 rtl/stream_demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 37 +++
 rtl/stream_demux.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and helpers for the stream demultiplexer.
//   state_t  - packet-lock FSM states
//   CNT_W    - width of the optional statistics counters
//   ch_valid - true when a select value addresses an existing channel
package stream_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int CNT_W = 16;

  function automatic logic ch_valid(input int unsigned sel, input int unsigned num_ch);
    return sel < num_ch;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: 1-entry registered output slot of the demultiplexer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en             load wr_data/wr_last into the slot (wins over drain)
//   wr_data, wr_last  payload and last flag to store
//   ready             consumer ready; slot drains on valid & ready
//   valid, data, last slot contents, held stable until drained
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // A write in the same cycle as a drain reloads the slot with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
      last  <= wr_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1:NUM_CH valid/ready stream demultiplexer with packet lock.
// The first beat of a packet selects the channel; the rest of the packet
// follows it regardless of in_sel. Out-of-range selects are accepted and
// discarded, pulsing drop one cycle later for each beat.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last/in_sel   input stream
//   out_valid/out_ready/out_data/out_last      per-channel outputs,
//                                   channel k at out_data[k*DATA_W +: DATA_W]
//   drop                            pulse per discarded beat
// Optional feature, macro STREAM_DEMUX_CNT_EN:
//   cnt_beats  16-bit accepted-beat counter per channel (wrapping)
//   cnt_drop   16-bit drop-pulse counter (wrapping)
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_last,
`ifdef STREAM_DEMUX_CNT_EN
  output logic [NUM_CH*CNT_W-1:0]  cnt_beats,
  output logic [CNT_W-1:0]         cnt_drop,
`endif
  output logic                     drop
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_sel_q, lock_sel_d;
  logic [SEL_W-1:0]  target;
  logic              tgt_ok;
  logic              accept;
  logic [NUM_CH-1:0] wr_en;

  // Routing: an out-of-range target has no slot, so it never backpressures.
  always_comb begin
    target   = (state_q == LOCKED) ? lock_sel_q : in_sel;
    tgt_ok   = ch_valid(32'(target), NUM_CH);
    in_ready = ~tgt_ok;
    for (int k = 0; k < NUM_CH; k++) begin
      if (target == SEL_W'(k)) begin
        in_ready = in_ready | ~out_valid[k] | out_ready[k];
      end
    end
    accept = in_valid & in_ready;
    wr_en  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_en[k] = accept & (target == SEL_W'(k));
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d    = LOCKED;
          lock_sel_d = in_sel;
        end
      end
      LOCKED: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
      drop       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      drop       <= accept & ~tgt_ok;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[k]),
      .wr_data (in_data),
      .wr_last (in_last),
      .ready   (out_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*DATA_W +: DATA_W]),
      .last    (out_last[k])
    );
  end

`ifdef STREAM_DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_beats <= '0;
      cnt_drop  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k]) cnt_beats[k*CNT_W +: CNT_W] <= cnt_beats[k*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if (drop) cnt_drop <= cnt_drop + CNT_W'(1);
    end
  end
`endif

endmodule
